ustc_psum_issue: RTL and testbench

- Producer side of the partial-sum line interface: accepts beats of NUM_IN product lanes (row, data, enable) for one column and drives the {ctrl,row,data} line bus, col and out_en into the psum accumulator.
- Splits any beat holding duplicate row indices across several cycles, so every emitted line carries unique rows; the accumulator's same-row update would otherwise drop terms.
- Sequences the accumulator's drain: flush, then an out_en pulse, then a wait until the readout completes.

---
 rtl/ustc_psum_issue.sv | 153 +++++++++++++++
 tb/tb_ustc_psum_issue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ustc_psum_issue.sv
// Purpose: partial-sum line issuer; splits beats with duplicate rows into unique-row lines and sequences the drain (flush, out_en pulse, readout wait).
// Latency: accept edge to first line edge is 1 cycle; a beat whose most-repeated row occurs k times takes k lines.
// Backpressure: in_ready drops while a beat still needs further lines and for the whole drain (FLUSH..WAIT_LO).
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid/in_ready          beat handshake; in_col, in_lane_en, in_row, in_data carry the beat
//   flush                      request a drain after all accepted beats are issued
//   col, line                  registered column and {ctrl,row,data} lanes of the current line
//   out_en                     one-cycle drain start to the accumulator
//   psum_out_valid             accumulator readout-active indicator
//   busy                       high while draining or while lanes are still pending
module ustc_psum_issue #(
    parameter int NUM_IN  = 32,
    parameter int DW_DATA = 32,
    parameter int DW_ROW  = 4,
    parameter int DW_COL  = 4,
    parameter int DW_CTRL = 4,
    parameter int DW_LINE = DW_DATA + DW_ROW + DW_CTRL
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DW_COL-1:0]         in_col,
    input  logic [NUM_IN-1:0]         in_lane_en,
    input  logic [NUM_IN*DW_ROW-1:0]  in_row,
    input  logic [NUM_IN*DW_DATA-1:0] in_data,
    input  logic                      flush,
    output logic [DW_COL-1:0]         col,
    output logic [NUM_IN*DW_LINE-1:0] line,
    output logic                      out_en,
    input  logic                      psum_out_valid,
    output logic                      busy
);

    typedef enum logic [2:0] {
        S_RUN,
        S_FLUSH,
        S_OUT_EN,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t                      state;
    logic [NUM_IN-1:0]           pending;
    logic [NUM_IN-1:0]           sel;
    logic [NUM_IN-1:0]           remain;
    logic [NUM_IN*DW_ROW-1:0]    held_row;
    logic [NUM_IN*DW_DATA-1:0]   held_data;
    logic [DW_COL-1:0]           held_col;
    logic [DW_CTRL-1:0]          ctrl_sel;
    logic [NUM_IN*DW_LINE-1:0]   line_next;
    logic                        accept;

    // First occurrence of each row among the pending lanes wins; later
    // duplicates wait for a following line. The lowest pending lane is
    // always selected, so a non-empty mask always makes progress.
    always_comb begin
        sel = pending;
        for (int i = 0; i < NUM_IN; i++) begin
            for (int j = 0; j < NUM_IN; j++) begin
                if (j < i && pending[j] &&
                    held_row[j*DW_ROW +: DW_ROW] == held_row[i*DW_ROW +: DW_ROW]) begin
                    sel[i] = 1'b0;
                end
            end
        end
    end

    assign remain = pending & ~sel;

    // A new beat may load in the same cycle the held beat issues its final line.
    assign in_ready = (state == S_RUN) && (remain == '0);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != S_RUN) || (pending != '0);

    // Lanes keep their positions; unselected lanes are all-zero.
    always_comb begin
        ctrl_sel              = '0;
        ctrl_sel[DW_CTRL-2]   = 1'b1;
        ctrl_sel[DW_CTRL-1]   = (remain == '0);
        line_next             = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel[i]) begin
                line_next[i*DW_LINE +: DW_LINE] = {ctrl_sel,
                                                   held_row[i*DW_ROW +: DW_ROW],
                                                   held_data[i*DW_DATA +: DW_DATA]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RUN;
            pending   <= '0;
            held_row  <= '0;
            held_data <= '0;
            held_col  <= '0;
            line      <= '0;
            col       <= '0;
            out_en    <= 1'b0;
        end else begin
            if (accept) begin
                held_row  <= in_row;
                held_data <= in_data;
                held_col  <= in_col;
                pending   <= in_lane_en;
            end else begin
                pending   <= remain;
            end

            line <= line_next;
            if (pending != '0) begin
                col <= held_col;
            end

            out_en <= 1'b0;
            case (state)
                S_RUN: begin
                    if (flush) begin
                        state <= S_FLUSH;
                    end
                end
                // pending==0 means nothing is emitted at this edge, so the
                // last valid line is already at least one cycle old.
                S_FLUSH: begin
                    if (pending == '0) begin
                        state  <= S_OUT_EN;
                        out_en <= 1'b1;
                    end
                end
                S_OUT_EN: begin
                    state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (psum_out_valid) begin
                        state <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (!psum_out_valid) begin
                        state <= S_RUN;
                    end
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ustc_psum_issue.sv
module tb_ustc_psum_issue;

    localparam int NI  = 4;
    localparam int DD  = 32;
    localparam int DR  = 4;
    localparam int DC  = 4;
    localparam int DT  = 4;
    localparam int DL  = DD + DR + DT;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [DC-1:0]      in_col = '0;
    logic [NI-1:0]      in_lane_en = '0;
    logic [NI*DR-1:0]   in_row = '0;
    logic [NI*DD-1:0]   in_data = '0;
    logic               flush = 1'b0;
    logic [DC-1:0]      col;
    logic [NI*DL-1:0]   line;
    logic               out_en;
    logic               psum_out_valid = 1'b0;
    logic               busy;

    int total = 0;
    int bad   = 0;

    ustc_psum_issue #(
        .NUM_IN(NI), .DW_DATA(DD), .DW_ROW(DR), .DW_COL(DC), .DW_CTRL(DT), .DW_LINE(DL)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_col(in_col), .in_lane_en(in_lane_en), .in_row(in_row), .in_data(in_data),
        .flush(flush), .col(col), .line(line), .out_en(out_en),
        .psum_out_valid(psum_out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Line monitor: counts valid lanes, lines and out_en cycles.
    int cyc = 0, lane_cnt = 0, line_cnt = 0, oe_cnt = 0, last_line_cyc = 0, oe_cyc = 0;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (line[0*DL+38] | line[1*DL+38] | line[2*DL+38] | line[3*DL+38]) begin
            line_cnt++;
            last_line_cyc = cyc;
        end
        for (int i = 0; i < NI; i++) if (line[i*DL+38]) lane_cnt++;
        if (out_en) begin
            oe_cnt++;
            oe_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] r4(input int a, input int b, input int c, input int d);
        logic [3:0] ra, rb, rc, rd;
        ra = a[3:0]; rb = b[3:0]; rc = c[3:0]; rd = d[3:0];
        return {rd, rc, rb, ra};
    endfunction

    function automatic logic [127:0] d4(input int a, input int b, input int c, input int d);
        return {d[31:0], c[31:0], b[31:0], a[31:0]};
    endfunction

    // Expected line: lanes in m carry ctrl {last,valid=1,0,0}, row, data.
    function automatic logic [159:0] mk(input logic [3:0] m, input logic last,
                                        input logic [15:0] r, input logic [127:0] d);
        logic [159:0] l;
        l = '0;
        for (int i = 0; i < NI; i++)
            if (m[i]) l[i*DL +: DL] = {last, 1'b1, 2'b00, r[i*DR +: DR], d[i*DD +: DD]};
        return l;
    endfunction

    typedef struct {
        logic         vld;
        logic [3:0]   bcol;
        logic [3:0]   en;
        logic [15:0]  row;
        logic [127:0] dat;
        logic         exp_rdy;
        logic [159:0] exp_line;
        logic [3:0]   exp_col;
        logic         exp_busy;
    } vec_t;

    vec_t tv[11];

    task automatic set_beat(input logic v, input logic [3:0] c, input logic [3:0] e,
                            input logic [15:0] r, input logic [127:0] d);
        in_valid = v; in_col = c; in_lane_en = e; in_row = r; in_data = d;
    endtask

    // Called at a negedge: offer a beat, wait (bounded) until it will be
    // accepted at the coming edge, optionally raising flush with it.
    task automatic offer(input logic [3:0] c, input logic [15:0] r, input logic [127:0] d,
                         input logic with_flush);
        int n;
        n = 0;
        set_beat(1'b1, c, 4'hf, r, d);
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL offer_timeout: in_ready never rose");
        end
        flush = with_flush;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
    endtask

    logic [15:0]  R1, R2, R3, RB1, RB2, RB3, RX, RR;
    logic [127:0] D1, D2, D3, DX;
    int base_lane, base_line, base_oe, ready_err, n;

    initial begin
        R1 = r4(1,2,5,7);  D1 = d4(10,20,30,40);
        R2 = r4(2,2,2,6);  D2 = d4(1,2,3,4);
        R3 = r4(4,4,4,4);  D3 = d4(7,8,9,10);

        tv[0]  = '{1'b0, 4'd0, 4'h0, 16'h0, 128'h0, 1'b1, 160'h0,                      4'd0, 1'b0};
        tv[1]  = '{1'b1, 4'd3, 4'hf, R1,    D1,     1'b1, 160'h0,                      4'd0, 1'b1};
        tv[2]  = '{1'b0, 4'd0, 4'h0, 16'h0, 128'h0, 1'b1, mk(4'hf, 1'b1, R1, D1),      4'd3, 1'b0};
        tv[3]  = '{1'b1, 4'd5, 4'hf, R2,    D2,     1'b1, 160'h0,                      4'd3, 1'b1};
        tv[4]  = '{1'b0, 4'd0, 4'h0, 16'h0, 128'h0, 1'b0, mk(4'b1001, 1'b0, R2, D2),   4'd5, 1'b1};
        tv[5]  = '{1'b0, 4'd0, 4'h0, 16'h0, 128'h0, 1'b0, mk(4'b0010, 1'b0, R2, D2),   4'd5, 1'b1};
        tv[6]  = '{1'b1, 4'd1, 4'b0101, R3, D3,     1'b1, mk(4'b0100, 1'b1, R2, D2),   4'd5, 1'b1};
        tv[7]  = '{1'b0, 4'd0, 4'h0, 16'h0, 128'h0, 1'b0, mk(4'b0001, 1'b0, R3, D3),   4'd1, 1'b1};
        tv[8]  = '{1'b0, 4'd0, 4'h0, 16'h0, 128'h0, 1'b1, mk(4'b0100, 1'b1, R3, D3),   4'd1, 1'b0};
        tv[9]  = '{1'b1, 4'd2, 4'h0, R1,    D1,     1'b1, 160'h0,                      4'd1, 1'b0};
        tv[10] = '{1'b0, 4'd0, 4'h0, 16'h0, 128'h0, 1'b1, 160'h0,                      4'd1, 1'b0};

        // Reset state
        #12;
        chk("rst_line",  line,     160'h0);
        chk("rst_col",   col,      160'h0);
        chk("rst_oe",    out_en,   160'h0);
        chk("rst_ready", in_ready, 160'h1);
        chk("rst_busy",  busy,     160'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table: inputs for one cycle, in_ready before the edge, outputs after it
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            set_beat(tv[k].vld, tv[k].bcol, tv[k].en, tv[k].row, tv[k].dat);
            #1;
            chk($sformatf("v%0d_ready", k), in_ready, tv[k].exp_rdy);
            @(posedge clk); #1;
            chk($sformatf("v%0d_line", k), line,   tv[k].exp_line);
            chk($sformatf("v%0d_col", k),  col,    tv[k].exp_col);
            chk($sformatf("v%0d_busy", k), busy,   tv[k].exp_busy);
            chk($sformatf("v%0d_oe", k),   out_en, 160'h0);
        end

        // Three back-to-back beats, flush with the last, then the drain
        @(negedge clk);
        RB1 = r4(0,1,2,3); RB2 = r4(5,5,6,7); RB3 = r4(8,9,10,11);
        RX  = r4(1,2,3,4); DX  = d4(99,98,97,96);
        base_lane = lane_cnt; base_line = line_cnt; base_oe = oe_cnt;
        offer(4'd4, RB1, d4(1,1,1,1), 1'b0);
        offer(4'd6, RB2, d4(2,2,2,2), 1'b0);
        offer(4'd7, RB3, d4(3,3,3,3), 1'b1);
        set_beat(1'b1, 4'd9, 4'hf, RX, DX);
        ready_err = 0;
        n = 0;
        #1;
        while (!out_en && n < 20) begin
            if (in_ready) ready_err++;
            @(negedge clk); #1;
            n++;
        end
        chk("oe_seen", out_en, 160'h1);
        chk("drain_lines", line_cnt - base_line, 160'd4);
        chk("drain_lanes", lane_cnt - base_lane, 160'd12);
        chk("oe_after_line", (oe_cyc > last_line_cyc) ? 1 : 0, 160'h1);
        psum_out_valid = 1'b1;
        repeat (17) begin
            @(negedge clk); #1;
            if (in_ready) ready_err++;
        end
        psum_out_valid = 1'b0;
        #1;
        chk("ready_at_fall", in_ready, 160'h0);
        chk("drain_ready", ready_err, 160'h0);
        chk("oe_once", oe_cnt - base_oe, 160'd1);
        @(negedge clk); #1;
        chk("ready_after_fall", in_ready, 160'h1);
        chk("busy_after_fall", busy, 160'h0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_stale_offer", lane_cnt - base_lane, 160'd12);

        // Reset mid-beat with pending = 0110
        RR = r4(3,3,3,9);
        offer(4'd2, RR, d4(5,6,7,8), 1'b0);
        in_valid = 1'b0;
        @(negedge clk); #1;
        chk("mid_line", line, mk(4'b1001, 1'b0, RR, d4(5,6,7,8)));
        chk("mid_ready", in_ready, 160'h0);
        rst = 1'b1;
        #1;
        chk("mid_rst_line",  line,     160'h0);
        chk("mid_rst_ready", in_ready, 160'h1);
        chk("mid_rst_busy",  busy,     160'h0);
        chk("mid_rst_oe",    out_en,   160'h0);
        @(negedge clk);
        rst = 1'b0;
        base_lane = lane_cnt;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_no_stale", lane_cnt - base_lane, 160'd0);
        chk("mid_ready_after", in_ready, 160'h1);

        // Reset during WAIT_HI
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n = 0;
        #1;
        while (!out_en && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        chk("wh_oe_seen", out_en, 160'h1);
        @(negedge clk); #1;
        chk("wh_busy", busy, 160'h1);
        chk("wh_ready", in_ready, 160'h0);
        rst = 1'b1;
        #1;
        chk("wh_rst_busy",  busy,     160'h0);
        chk("wh_rst_ready", in_ready, 160'h1);
        chk("wh_rst_oe",    out_en,   160'h0);
        chk("wh_rst_line",  line,     160'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("wh_after_busy", busy, 160'h0);
        chk("wh_after_ready", in_ready, 160'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
